// File: rtl/regfile_sb_pkg.sv
// Purpose: shared types, depth computation and port-slice helper for the register file and related multi-port datapath blocks.
// Latency: none; holds only types, constants and constant functions.
// Backpressure: none.
package regfile_sb_pkg;

    // Two-state lifecycle: sweep the array to zero, then normal operation.
    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    // Number of registers addressed by an addrW-bit address.
    function automatic int calcDepth(input int addrW);
        return 1 << addrW;
    endfunction

    localparam int DEF_ADDR_W = 5;
    localparam int DEF_DEPTH  = calcDepth(DEF_ADDR_W);

    // Low bit of port `port` inside a packed bus of `width`-bit slices.
    function automatic int portLo(input int port, input int width);
        return port * width;
    endfunction

endpackage

// File: rtl/regfile_sb_if.sv
// Purpose: decode/writeback bus of the register file (read ports, write port, scoreboard set, Ready).
// Latency: n/a; master drives addresses/strobes, slave returns combinational read data and pending bits.
// Backpressure: none; the master must hold off until Ready is high.
// Ports: RdAddr/RdData/RdPending packed per read port, WrEn/WrAddr/WrData, SetEn/SetAddr, Ready.
interface regfile_sb_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
);
    logic                     Ready;
    logic [NUM_RD*ADDR_W-1:0] RdAddr;
    logic [NUM_RD*DATA_W-1:0] RdData;
    logic [NUM_RD-1:0]        RdPending;
    logic                     WrEn;
    logic [ADDR_W-1:0]        WrAddr;
    logic [DATA_W-1:0]        WrData;
    logic                     SetEn;
    logic [ADDR_W-1:0]        SetAddr;

    modport master (
        input  Ready, RdData, RdPending,
        output RdAddr, WrEn, WrAddr, WrData, SetEn, SetAddr
    );

    modport slave (
        output Ready, RdData, RdPending,
        input  RdAddr, WrEn, WrAddr, WrData, SetEn, SetAddr
    );
endinterface

// File: rtl/regfile_sb_rdport.sv
// Purpose: one read port: zero-register forcing, same-cycle write bypass, pending-bit mux.
// Latency: purely combinational from rdAddr / write port to rdData / rdPending.
// Backpressure: none.
// Ports: run (array usable), rdAddr, arrData/arrPending (array contents at rdAddr),
//        wrEn/wrAddr/wrData (writeback this cycle), rdData/rdPending (port outputs).
module regfile_rdport #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              run,
    input  logic [ADDR_W-1:0] rdAddr,
    input  logic [DATA_W-1:0] arrData,
    input  logic              arrPending,
    input  logic              wrEn,
    input  logic [ADDR_W-1:0] wrAddr,
    input  logic [DATA_W-1:0] wrData,
    output logic [DATA_W-1:0] rdData,
    output logic              rdPending
);
    logic isZero;
    logic isBypass;

    assign isZero   = (ZERO_REG != 0) && (rdAddr == '0);
    assign isBypass = (BYPASS != 0) && wrEn && (wrAddr == rdAddr);

    always_comb begin
        rdData    = '0;
        rdPending = 1'b0;
        // While clearing, stale array contents must not leak out.
        if (run && !isZero) begin
            if (isBypass) begin
                // The write lands this edge, which also clears the pending bit.
                rdData = wrData;
            end else begin
                rdData    = arrData;
                rdPending = arrPending;
            end
        end
    end
endmodule

// File: rtl/regfile_sb.sv
// Purpose: parametrised register file with write-to-read bypass, pending-write scoreboard and reset clear sweep.
// Latency: writes/scoreboard updates one edge; reads combinational; Ready DEPTH cycles after Rst falls.
// Backpressure: none; writes and sets are dropped until Ready.
// Ports: Clk, Rst (sync, active-high), bus (slave side of regfile_sb_if).
module regfile_sb
    import regfile_sb_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic       Clk,
    input  logic       Rst,
    regfile_sb_if.slave bus
);
    localparam int DEPTH = calcDepth(ADDR_W);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  pending;
    logic [ADDR_W-1:0] cnt;
    state_t            state;
    logic              readyQ;

    logic isRun;
    logic wrOk;
    logic setOk;

    assign isRun = (state == ST_RUN);
    assign wrOk  = isRun && bus.WrEn  && !((ZERO_REG != 0) && (bus.WrAddr  == '0));
    assign setOk = isRun && bus.SetEn && !((ZERO_REG != 0) && (bus.SetAddr == '0));

    assign bus.Ready = readyQ;

    // Control: FSM, clear counter and scoreboard.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state   <= ST_CLEAR;
            cnt     <= '0;
            pending <= '0;
            readyQ  <= 1'b0;
        end else begin
            case (state)
                ST_CLEAR: begin
                    cnt <= cnt + 1'b1;
                    // DEPTH is a power of two, so the last entry is all-ones.
                    if (&cnt) begin
                        state  <= ST_RUN;
                        readyQ <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (wrOk) begin
                        pending[bus.WrAddr] <= 1'b0;
                    end
                    // Placed after the clear so a same-address set wins.
                    if (setOk) begin
                        pending[bus.SetAddr] <= 1'b1;
                    end
                end
                default: state <= ST_CLEAR;
            endcase
        end
    end

    // Array kept free of reset so it maps onto plain storage; the sweep zeroes it instead.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            if (state == ST_CLEAR) begin
                mem[cnt] <= '0;
            end else if (wrOk) begin
                mem[bus.WrAddr] <= bus.WrData;
            end
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : gRd
        localparam int AL = portLo(i, ADDR_W);
        localparam int DL = portLo(i, DATA_W);

        logic [ADDR_W-1:0] addr;
        assign addr = bus.RdAddr[AL +: ADDR_W];

        regfile_rdport #(
            .DATA_W  (DATA_W),
            .ADDR_W  (ADDR_W),
            .ZERO_REG(ZERO_REG),
            .BYPASS  (BYPASS)
        ) uPort (
            .run       (isRun),
            .rdAddr    (addr),
            .arrData   (mem[addr]),
            .arrPending(pending[addr]),
            .wrEn      (bus.WrEn),
            .wrAddr    (bus.WrAddr),
            .wrData    (bus.WrData),
            .rdData    (bus.RdData[DL +: DATA_W]),
            .rdPending (bus.RdPending[i])
        );
    end
endmodule

// File: tb/tb_regfile_sb.sv
// Purpose: self-checking bench for regfile_sb: default, no-bypass and small (16x8, 3 ports, no zero reg) builds.
// Latency: n/a.
// Backpressure: n/a.
module tb_regfile_sb;

    logic Clk;
    logic Rst;

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    regfile_sb_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) busA ();
    regfile_sb_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) busB ();
    regfile_sb_if #(.DATA_W(16), .ADDR_W(3), .NUM_RD(3)) busC ();

    // The no-bypass build sees exactly the same stimulus as the default build.
    assign busB.RdAddr  = busA.RdAddr;
    assign busB.WrEn    = busA.WrEn;
    assign busB.WrAddr  = busA.WrAddr;
    assign busB.WrData  = busA.WrData;
    assign busB.SetEn   = busA.SetEn;
    assign busB.SetAddr = busA.SetAddr;

    regfile_sb dutA (.Clk(Clk), .Rst(Rst), .bus(busA));
    regfile_sb #(.BYPASS(0)) dutB (.Clk(Clk), .Rst(Rst), .bus(busB));
    regfile_sb #(.DATA_W(16), .ADDR_W(3), .NUM_RD(3), .ZERO_REG(0)) dutC (.Clk(Clk), .Rst(Rst), .bus(busC));

    int vectors;
    int miscompares;

    // Reference model for the 32x32 builds: register contents, pending set,
    // and the number of clear cycles still to elapse before the file is usable.
    logic [31:0] mMem [32];
    logic [31:0] mPend;
    int          mLeft;

    typedef struct {
        logic        wrEn;
        logic [4:0]  wrAddr;
        logic [31:0] wrData;
        logic        setEn;
        logic [4:0]  setAddr;
        logic [4:0]  rd0;
        logic [4:0]  rd1;
        logic [31:0] exp0;
        logic [31:0] exp1;
        logic [1:0]  expPend;
        logic [31:0] expB0;
    } vec_t;

    vec_t tbl [11];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic modelTick();
        if (Rst) begin
            mLeft = 32;
            mPend = '0;
            for (int i = 0; i < 32; i++) mMem[i] = 32'h0;
        end else if (mLeft > 0) begin
            mLeft--;
        end else begin
            if (busA.WrEn && busA.WrAddr != 5'd0) begin
                mMem[busA.WrAddr]  = busA.WrData;
                mPend[busA.WrAddr] = 1'b0;
            end
            if (busA.SetEn && busA.SetAddr != 5'd0) mPend[busA.SetAddr] = 1'b1;
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        modelTick();
        #1;
    endtask

    function automatic logic [31:0] expData(input logic [4:0] a, input bit byp);
        if (mLeft != 0 || a == 5'd0) return 32'h0;
        if (byp && busA.WrEn && busA.WrAddr == a) return busA.WrData;
        return mMem[a];
    endfunction

    function automatic logic expPend(input logic [4:0] a, input bit byp);
        if (mLeft != 0 || a == 5'd0) return 1'b0;
        if (byp && busA.WrEn && busA.WrAddr == a) return 1'b0;
        return mPend[a];
    endfunction

    task automatic modelCheck();
        chk("rnd.A.Ready", 64'(busA.Ready), 64'(mLeft == 0));
        chk("rnd.B.Ready", 64'(busB.Ready), 64'(mLeft == 0));
        for (int p = 0; p < 2; p++) begin
            logic [4:0] a;
            a = busA.RdAddr[p*5 +: 5];
            chk($sformatf("rnd.A.data%0d", p), 64'(busA.RdData[p*32 +: 32]), 64'(expData(a, 1'b1)));
            chk($sformatf("rnd.A.pend%0d", p), 64'(busA.RdPending[p]), 64'(expPend(a, 1'b1)));
            chk($sformatf("rnd.B.data%0d", p), 64'(busB.RdData[p*32 +: 32]), 64'(expData(a, 1'b0)));
            chk($sformatf("rnd.B.pend%0d", p), 64'(busB.RdPending[p]), 64'(expPend(a, 1'b0)));
        end
    endtask

    task automatic idleA();
        busA.WrEn    = 1'b0;
        busA.WrAddr  = 5'd0;
        busA.WrData  = 32'h0;
        busA.SetEn   = 1'b0;
        busA.SetAddr = 5'd0;
        busA.RdAddr  = 10'd0;
    endtask

    initial begin
        int nA;
        int nC;
        vectors     = 0;
        miscompares = 0;
        mLeft       = 32;
        mPend       = '0;
        for (int i = 0; i < 32; i++) mMem[i] = 32'h0;

        //               wrEn  wrAddr wrData         setEn setAddr rd0    rd1    exp0           exp1           pend   expB0
        tbl[0]  = '{1'b1, 5'd7, 32'hDEADBEEF, 1'b0, 5'd0, 5'd7, 5'd7, 32'hDEADBEEF, 32'hDEADBEEF, 2'b00, 32'h0};
        tbl[1]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd7, 5'd7, 32'hDEADBEEF, 32'hDEADBEEF, 2'b00, 32'hDEADBEEF};
        tbl[2]  = '{1'b1, 5'd0, 32'h1234,     1'b1, 5'd0, 5'd0, 5'd0, 32'h0,        32'h0,        2'b00, 32'h0};
        tbl[3]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd0, 5'd0, 32'h0,        32'h0,        2'b00, 32'h0};
        tbl[4]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd3, 5'd3, 5'd3, 32'h0,        32'h0,        2'b00, 32'h0};
        tbl[5]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd3, 5'd3, 32'h0,        32'h0,        2'b11, 32'h0};
        tbl[6]  = '{1'b1, 5'd3, 32'h55,       1'b0, 5'd0, 5'd3, 5'd3, 32'h55,       32'h55,       2'b00, 32'h0};
        tbl[7]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd3, 5'd3, 32'h55,       32'h55,       2'b00, 32'h55};
        tbl[8]  = '{1'b1, 5'd3, 32'h66,       1'b1, 5'd3, 5'd3, 5'd3, 32'h66,       32'h66,       2'b00, 32'h55};
        tbl[9]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd3, 5'd3, 32'h66,       32'h66,       2'b11, 32'h66};
        tbl[10] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd7, 5'd3, 32'hDEADBEEF, 32'h66,       2'b10, 32'hDEADBEEF};

        Rst = 1'b1;
        idleA();
        busC.WrEn    = 1'b0;
        busC.WrAddr  = 3'd0;
        busC.WrData  = 16'h0;
        busC.SetEn   = 1'b0;
        busC.SetAddr = 3'd0;
        busC.RdAddr  = 9'd0;

        // Reset state and clear-sequence length.
        repeat (3) tick();
        @(negedge Clk);
        chk("rst.A.Ready", 64'(busA.Ready), 64'd0);
        chk("rst.A.RdData", 64'(busA.RdData), 64'd0);
        chk("rst.A.RdPending", 64'(busA.RdPending), 64'd0);
        chk("rst.C.Ready", 64'(busC.Ready), 64'd0);
        Rst = 1'b0;
        nA = 0;
        nC = 0;
        for (int n = 1; n <= 64 && nA == 0; n++) begin
            tick();
            if (busC.Ready && nC == 0) nC = n;
            if (busA.Ready) nA = n;
        end
        chk("clr.A.readyCycles", 64'(nA), 64'd32);
        chk("clr.C.readyCycles", 64'(nC), 64'd8);
        for (int r = 0; r < 32; r += 2) begin
            busA.RdAddr = {5'(r + 1), 5'(r)};
            #1;
            chk($sformatf("clr.rd%0d", r), 64'(busA.RdData), 64'd0);
            chk($sformatf("clr.pend%0d", r), 64'(busA.RdPending), 64'd0);
        end

        // Reset partway through a clear; writes during the sweep are dropped.
        Rst = 1'b1;
        tick();
        Rst = 1'b0;
        repeat (10) tick();
        Rst          = 1'b1;
        busA.WrEn    = 1'b1;
        busA.WrAddr  = 5'd5;
        busA.WrData  = 32'hFFFFFFFF;
        busA.SetEn   = 1'b1;
        busA.SetAddr = 5'd5;
        busA.RdAddr  = {5'd5, 5'd5};
        tick();
        Rst = 1'b0;
        nA  = 0;
        for (int n = 1; n <= 64 && nA == 0; n++) begin
            if (n == 20) begin
                @(negedge Clk);
                chk("midclr.noBypass", 64'(busA.RdData), 64'd0);
                chk("midclr.noPend", 64'(busA.RdPending), 64'd0);
            end
            tick();
            if (busA.Ready) begin
                nA         = n;
                busA.WrEn  = 1'b0;
                busA.SetEn = 1'b0;
            end
        end
        chk("midclr.readyCycles", 64'(nA), 64'd32);
        #1;
        chk("midclr.reg5", 64'(busA.RdData), 64'd0);
        chk("midclr.pend5", 64'(busA.RdPending), 64'd0);

        // Directed bypass / zero-register / scoreboard vectors.
        for (int i = 0; i < 11; i++) begin
            busA.WrEn    = tbl[i].wrEn;
            busA.WrAddr  = tbl[i].wrAddr;
            busA.WrData  = tbl[i].wrData;
            busA.SetEn   = tbl[i].setEn;
            busA.SetAddr = tbl[i].setAddr;
            busA.RdAddr  = {tbl[i].rd1, tbl[i].rd0};
            @(negedge Clk);
            chk($sformatf("tbl[%0d].A0", i), 64'(busA.RdData[31:0]), 64'(tbl[i].exp0));
            chk($sformatf("tbl[%0d].A1", i), 64'(busA.RdData[63:32]), 64'(tbl[i].exp1));
            chk($sformatf("tbl[%0d].pend", i), 64'(busA.RdPending), 64'(tbl[i].expPend));
            chk($sformatf("tbl[%0d].B0", i), 64'(busB.RdData[31:0]), 64'(tbl[i].expB0));
            tick();
        end
        idleA();

        // Randomised traffic against the model, concentrated on a few registers.
        for (int k = 0; k < 600; k++) begin
            Rst          = ($urandom_range(0, 399) == 0);
            busA.WrEn    = 1'($urandom_range(0, 1));
            busA.WrAddr  = 5'($urandom_range(0, 7));
            busA.WrData  = $urandom;
            busA.SetEn   = ($urandom_range(0, 2) == 0);
            busA.SetAddr = 5'($urandom_range(0, 7));
            busA.RdAddr  = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            @(negedge Clk);
            modelCheck();
            tick();
        end
        Rst = 1'b0;
        idleA();

        // Small build: 16-bit, 8 registers, 3 ports, register 0 is ordinary.
        repeat (12) tick();
        chk("C.Ready", 64'(busC.Ready), 64'd1);
        busC.WrEn   = 1'b1;
        busC.WrAddr = 3'd0;
        busC.WrData = 16'hA5A5;
        busC.RdAddr = {3'd0, 3'd0, 3'd0};
        @(negedge Clk);
        chk("C.bypass", 64'(busC.RdData), 64'({3{16'hA5A5}}));
        tick();
        busC.WrEn    = 1'b0;
        busC.SetEn   = 1'b1;
        busC.SetAddr = 3'd0;
        @(negedge Clk);
        chk("C.stored", 64'(busC.RdData), 64'({3{16'hA5A5}}));
        chk("C.setNotYet", 64'(busC.RdPending), 64'd0);
        tick();
        busC.SetEn  = 1'b0;
        busC.WrEn   = 1'b1;
        busC.WrAddr = 3'd7;
        busC.WrData = 16'h1357;
        @(negedge Clk);
        chk("C.pend0", 64'(busC.RdPending), 64'b111);
        tick();
        busC.WrEn   = 1'b0;
        busC.RdAddr = {3'd7, 3'd0, 3'd7};
        @(negedge Clk);
        chk("C.mixData", 64'(busC.RdData), 64'({16'h1357, 16'hA5A5, 16'h1357}));
        chk("C.mixPend", 64'(busC.RdPending), 64'b010);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised register file with write-to-read bypass, a per-register scoreboard of pending writes, and a self-clearing synchronous reset sequencer. It sits in the CPU datapath between decode (read ports, scoreboard set) and writeback (write port, scoreboard clear). It generalises the fixed 32x32, two-read-port register file in width, depth and read-port count. It also replaces negedge writes with rising-edge writes plus same-cycle bypass.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W registers
- NUM_RD, 2, number of read ports (1..4)
- ZERO_REG, 1, when 1 register 0 reads as 0, is never written and is never pending
- BYPASS, 1, when 1 a same-cycle write is forwarded to matching read ports

- Clk  in  1  single clock; all state updates on the rising edge
- Rst  in  1  synchronous, active-high reset
- Ready  out  1  high when the clear sequence is complete and the file is usable
- RdAddr  in  NUM_RD*ADDR_W  read addresses; port i uses bits [i*ADDR_W +: ADDR_W]
- RdData  out  NUM_RD*DATA_W  read data, combinational from RdAddr
- RdPending  out  NUM_RD  scoreboard bit of each addressed register
- WrEn  in  1  write strobe (writeback)
- WrAddr  in  ADDR_W  write address
- WrData  in  DATA_W  write data
- SetEn  in  1  mark register SetAddr pending (instruction issued with destination)
- SetAddr  in  ADDR_W  scoreboard set address

## Operation
- The state machine has two states, CLEAR and RUN. A clear counter `cnt` has width ADDR_W.
- Rst high at any edge, in either state and including mid-CLEAR: state <= CLEAR, cnt <= 0, all pending bits <= 0. No array write occurs on that edge.
- CLEAR with Rst low: mem[cnt] <= 0 and cnt <= cnt+1. When cnt == DEPTH-1, state <= RUN.
- In CLEAR, WrEn and SetEn are ignored, RdData is 0 and RdPending is 0 on all ports.
- RUN write: WrEn=1 gives mem[WrAddr] <= WrData and pending[WrAddr] <= 0. With ZERO_REG=1 and WrAddr=0, nothing changes.
- RUN set: SetEn=1 gives pending[SetAddr] <= 1. This is ignored for address 0 when ZERO_REG=1.
- If SetEn and WrEn target the same address in the same cycle, the set wins: the bit ends at 1 and the data is still written.
- RUN read on port i with address a:
  - If ZERO_REG=1 and a=0: data 0, pending 0.
  - Else if BYPASS=1, WrEn=1 and WrAddr=a: data is WrData and pending is 0.
  - Else: data is mem[a] and pending is pending[a].
- A SetEn in the same cycle is not reflected on RdPending until the next cycle.
- All read ports are independent. Any number of ports may read the same address.
- With BYPASS=0, a read observes a write starting the cycle after the write edge.

## Timing
- Reset values: Ready=0, RdData=0, RdPending=0, pending vector all 0, state=CLEAR, cnt=0.
- If Rst is sampled high at edge E0 and low from E1, array clears occur at edges E1..E_DEPTH. Ready is registered and goes to 1 after edge E_DEPTH, i.e. DEPTH cycles after Rst falls.
- Write latency is one edge. Bypassed read latency is 0 (combinational).
- Scoreboard set and clear latency is one edge.
- Ready stays 1 until the next Rst. There is no other way to return to CLEAR.

## Structure
- The shared package holds:
  - the state encoding (ST_CLEAR, ST_RUN)
  - the localparam DEPTH computation
  - a function for indexing packed read-port slices, reused by the other multi-port datapath blocks
- One sub-module, `regfile_rdport`, is instantiated NUM_RD times in a generate loop. It contains the zero-register, bypass and pending-mux logic for a single port.
- The array, scoreboard vector, counter and FSM stay in the top module.

## Test plan
- Clear sequence: hold Rst 3 cycles, release, then count cycles. Ready must rise exactly 32 cycles after release; every register must read 0 and every RdPending must be 0.
- Reset mid-clear: assert Rst at clear cycle 10, release. Ready must rise 32 cycles after the second release. WrEn=1 to addr 5 issued during CLEAR must leave reg 5 reading 0.
- Write then read with bypass:
  - WrEn to addr 7 with 0xDEADBEEF, RdAddr[0]=7 in the same cycle: RdData[0]=0xDEADBEEF immediately.
  - Next cycle: still 0xDEADBEEF.
  - With BYPASS=0 the same-cycle read returns the old value 0.
- Zero register: WrEn to addr 0 with 0x1234 and SetEn to addr 0, then read addr 0 on both ports: data 0, pending 0.
- Scoreboard:
  - SetEn addr 3: RdPending 0 in the same cycle, 1 the next cycle.
  - WrEn addr 3 with 0x55: RdPending=0 in that cycle via bypass and afterwards.
  - SetEn and WrEn to addr 3 in the same cycle: pending=1 and data=new value afterwards.
- Parametrisation: DATA_W=16, ADDR_W=3, NUM_RD=3, ZERO_REG=0.
  - Ready is 8 cycles after reset.
  - Write 0xA5A5 to addr 0: all three ports reading addr 0 return 0xA5A5.
